rvcpu_run_monitor: RTL and testbench

Synthesizable run-control and end-of-test monitor for RVCPU simulation and FPGA bring-up. It replaces fixed-delay testbench control (a hard reset pulse and a hard stop time) with parametrised behaviour:
- a stretched CPU reset;
- cycle and retire counters;
- halt detection on ECALL/EBREAK/self-jump;
- a stuck-PC detector;
- a cycle watchdog.

It sits beside the core, drives the core's reset, and taps the core's retire stream. Its sticky `done`, `pass`, `fail` and `timeout` flags let a bench end simulation, and let a board drive LEDs.

---
 rtl/rvcpu_run_monitor.sv | 164 ++++++++++++++++
 tb/tb_rvcpu_run_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rvcpu_run_monitor.sv
// Run-control and end-of-test monitor for RVCPU: stretched core reset, cycle/retire
// counters, halt/stuck-PC detection and a cycle watchdog with sticky result flags.
module rvcpu_run_monitor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned MAX_CYCLES  = 100,
  parameter int unsigned STALL_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire_valid,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [31:0]       retire_inst,
  input  logic [XLEN-1:0]   a0_value,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-1:0]   exit_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retire_count
);

  localparam int unsigned HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned RUN_W  = $clog2(STALL_LIMIT + 1);

  localparam logic [31:0]      INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0]      INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0]      INST_SELFJ  = 32'h0000_006F;
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [RUN_W-1:0]  run_len_q, run_len_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic              seen_q, seen_d;

  logic              cpu_rst_d, running_d, done_d, pass_d, fail_d, timeout_d;
  logic [XLEN-1:0]   exit_code_d;
  logic [CNT_W-1:0]  cycle_count_d, retire_count_d;

  logic              halt_c, stuck_c, wdog_c, same_pc_c;

  // Termination event decode, priority resolved in the next-state logic.
  always_comb begin
    same_pc_c = seen_q && (retire_pc == last_pc_q);
    halt_c    = retire_valid && ((retire_inst == INST_ECALL) ||
                                 (retire_inst == INST_EBREAK) ||
                                 (retire_inst == INST_SELFJ));
    stuck_c   = retire_valid && same_pc_c && (run_len_q == RUN_W'(STALL_LIMIT - 1));
    wdog_c    = (cycle_count == WDOG_LAST);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    run_len_d      = run_len_q;
    last_pc_d      = last_pc_q;
    seen_d         = seen_q;
    cpu_rst_d      = cpu_rst;
    running_d      = running;
    done_d         = done;
    pass_d         = pass;
    fail_d         = fail;
    timeout_d      = timeout;
    exit_code_d    = exit_code;
    cycle_count_d  = cycle_count;
    retire_count_d = retire_count;

    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES)) begin
          state_d   = S_RUN;
          cpu_rst_d = 1'b0;
          running_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      S_RUN: begin
        if (cycle_count != CNT_SAT) cycle_count_d = cycle_count + CNT_W'(1);
        if (retire_valid) begin
          if (retire_count != CNT_SAT) retire_count_d = retire_count + CNT_W'(1);
          last_pc_d = retire_pc;
          seen_d    = 1'b1;
          run_len_d = same_pc_c ? run_len_q + RUN_W'(1) : RUN_W'(1);
        end

        if (halt_c) begin
          pass_d      = (a0_value == '0);
          fail_d      = (a0_value != '0);
          exit_code_d = a0_value;
        end else if (stuck_c) begin
          fail_d      = 1'b1;
          exit_code_d = retire_pc;
        end else if (wdog_c) begin
          fail_d      = 1'b1;
          timeout_d   = 1'b1;
          // last_pc_q is zero until the first retirement
          exit_code_d = retire_valid ? retire_pc : last_pc_q;
        end

        if (halt_c || stuck_c || wdog_c) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b1;
          running_d = 1'b0;
        end
      end

      default: begin
        state_d = S_DONE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HOLD;
      hold_q       <= '0;
      run_len_q    <= '0;
      last_pc_q    <= '0;
      seen_q       <= 1'b0;
      cpu_rst      <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      exit_code    <= '0;
      cycle_count  <= '0;
      retire_count <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      run_len_q    <= run_len_d;
      last_pc_q    <= last_pc_d;
      seen_q       <= seen_d;
      cpu_rst      <= cpu_rst_d;
      running      <= running_d;
      done         <= done_d;
      pass         <= pass_d;
      fail         <= fail_d;
      timeout      <= timeout_d;
      exit_code    <= exit_code_d;
      cycle_count  <= cycle_count_d;
      retire_count <= retire_count_d;
    end
  end

endmodule

// File: tb/tb_rvcpu_run_monitor.sv
// Self-checking bench for rvcpu_run_monitor: directed plan scenarios plus random runs,
// every cycle compared against a behavioural model of the run rules.
module tb_rvcpu_run_monitor;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned RST_CYCLES  = 3;
  localparam int unsigned MAX_CYCLES  = 100;
  localparam int unsigned STALL_LIMIT = 4;

  localparam logic [31:0] ADDI   = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] SELFJ  = 32'h0000_006F;

  logic             clk;
  logic             rst;
  logic             retire_valid;
  logic [XLEN-1:0]  retire_pc;
  logic [31:0]      retire_inst;
  logic [XLEN-1:0]  a0_value;
  logic             cpu_rst, running, done, pass, fail, timeout;
  logic [XLEN-1:0]  exit_code;
  logic [CNT_W-1:0] cycle_count, retire_count;

  rvcpu_run_monitor #(
    .XLEN(XLEN), .CNT_W(CNT_W), .RST_CYCLES(RST_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .STALL_LIMIT(STALL_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_inst(retire_inst), .a0_value(a0_value), .cpu_rst(cpu_rst),
    .running(running), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .exit_code(exit_code), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset release, run totals and retired-PC history.
  int          m_edges;
  bit          m_done, m_pass, m_fail, m_to;
  logic [31:0] m_exit;
  int          m_cyc, m_ret;
  logic [31:0] m_pcs[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit m_running();
    return !m_done && (m_edges > int'(RST_CYCLES));
  endfunction

  function automatic bit stuck_now(input logic [31:0] pc);
    if (m_pcs.size() < int'(STALL_LIMIT)) return 1'b0;
    for (int i = 0; i < int'(STALL_LIMIT); i++)
      if (m_pcs[m_pcs.size() - 1 - i] != pc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit rv, input logic [31:0] pc,
                            input logic [31:0] inst, input logic [31:0] a0);
    if (r) begin
      m_edges = 0; m_done = 0; m_pass = 0; m_fail = 0; m_to = 0;
      m_exit = '0; m_cyc = 0; m_ret = 0; m_pcs.delete();
    end else if (!m_done) begin
      if (m_edges > int'(RST_CYCLES)) begin
        m_cyc++;
        if (rv) begin
          m_ret++;
          m_pcs.push_back(pc);
        end
        if (rv && (inst == ECALL || inst == EBREAK || inst == SELFJ)) begin
          m_done = 1; m_pass = (a0 == 0); m_fail = (a0 != 0); m_exit = a0;
        end else if (rv && stuck_now(pc)) begin
          m_done = 1; m_fail = 1; m_exit = pc;
        end else if (m_cyc == int'(MAX_CYCLES)) begin
          m_done = 1; m_fail = 1; m_to = 1;
          m_exit = (m_pcs.size() > 0) ? m_pcs[m_pcs.size() - 1] : 32'h0;
        end
      end
      m_edges++;
    end
  endtask

  task automatic compare_all();
    chk("cpu_rst",      64'(cpu_rst),      64'(!m_running()));
    chk("running",      64'(running),      64'(m_running()));
    chk("done",         64'(done),         64'(m_done));
    chk("pass",         64'(pass),         64'(m_pass));
    chk("fail",         64'(fail),         64'(m_fail));
    chk("timeout",      64'(timeout),      64'(m_to));
    chk("exit_code",    64'(exit_code),    64'(m_exit));
    chk("cycle_count",  64'(cycle_count),  64'(m_cyc));
    chk("retire_count", 64'(retire_count), 64'(m_ret));
    chk("pass_and_fail", 64'(pass & fail), 64'(0));
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic [31:0] a0);
    rst = r; retire_valid = rv; retire_pc = pc; retire_inst = inst; a0_value = a0;
    @(posedge clk);
    model_edge(r, rv, pc, inst, a0);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, ADDI, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, ADDI, 32'h0);
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] a0);
    step(1'b0, 1'b1, pc, inst, a0);
  endtask

  task automatic reach_run();
    for (int i = 0; i < 20 && !m_running(); i++) idle(1);
  endtask

  initial begin
    logic [31:0] pc, inst, a0;
    bit          rv;
    int          len;

    rst = 1'b1; retire_valid = 1'b0; retire_pc = '0; retire_inst = '0; a0_value = '0;

    // Reset stretch, with retirements during HOLD that must be ignored
    do_reset(2);
    retire(32'h10, ECALL, 32'h0);
    retire(32'h10, ADDI, 32'h0);
    idle(4);

    // ECALL pass after five ordinary retirements
    do_reset(1); reach_run();
    for (int i = 0; i < 5; i++) retire(32'(i * 4), ADDI, 32'h5);
    retire(32'h14, ECALL, 32'h0);
    chk("ecall_retire_count", 64'(retire_count), 64'd6);
    retire(32'h18, ADDI, 32'h0);
    idle(3);

    // EBREAK with nonzero a0
    do_reset(1); reach_run();
    idle(2);
    retire(32'h80, EBREAK, 32'h2A);
    chk("ebreak_exit", 64'(exit_code), 64'h2A);
    idle(2);

    // Stuck PC, then a near miss broken by a new PC
    do_reset(1); reach_run();
    for (int i = 0; i < 4; i++) retire(32'h40, ADDI, 32'h0);
    chk("stuck_exit", 64'(exit_code), 64'h40);
    do_reset(1); reach_run();
    for (int i = 0; i < 3; i++) begin retire(32'h40, ADDI, 32'h0); idle(1); end
    retire(32'h44, ADDI, 32'h0);
    retire(32'h44, ADDI, 32'h0);
    chk("near_miss_done", 64'(done), 64'd0);

    // Watchdog, then a halt in the final watchdog cycle
    do_reset(1); reach_run();
    retire(32'h100, ADDI, 32'h0);
    idle(105);
    chk("wdog_cycles", 64'(cycle_count), 64'(MAX_CYCLES));
    do_reset(1); reach_run();
    idle(int'(MAX_CYCLES) - 1);
    retire(32'h200, SELFJ, 32'h0);
    chk("halt_beats_wdog", 64'(timeout), 64'd0);
    idle(2);

    // Mid-run reset, then reset from DONE
    do_reset(1); reach_run();
    idle(50);
    do_reset(1);
    idle(110);
    do_reset(1);
    idle(10);

    // Randomized runs
    for (int run = 0; run < 30; run++) begin
      do_reset(1 + int'($urandom_range(0, 1)));
      len = int'($urandom_range(20, 130));
      pc = 32'h1000;
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset(1);
          continue;
        end
        rv = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 9) < 3) pc = pc + 32'h4;
        case ($urandom_range(0, 59))
          0:       inst = ECALL;
          1:       inst = EBREAK;
          2:       inst = SELFJ;
          default: inst = (rv ? ADDI : 32'($urandom_range(0, 3) == 0 ? ECALL : ADDI));
        endcase
        a0 = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        step(1'b0, rv, pc, inst, a0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
